stopwatch_core: RTL and testbench
=================================

// Module: stopwatch_core
// PURPOSE
//  Two-button stopwatch (MM:SS.cc, 00:00.00..59:59.99) driven by a 1 kHz system clock.
//  Debounces a start/pause button and a clear button, counts hundredths of a second while running,
//  and drives a 6-digit multiplexed 7-segment display. Top-level user block; buttons come straight from pins.
// PARAMETERS
//  DEBOUNCE_CYCLES  10  consecutive high samples (10 ms @1 kHz) needed to accept a press
//  TICK_DIV         10  clocks per 0.01 s count step
// PORTS
//  clk_in        in   1   system clock, 1 kHz; all logic on rising edge
//  sys_rst_in    in   1   system reset, synchronous, active-high
//  ps_in         in   1   start/pause button, raw async, active-high
//  rst_in        in   1   clear button, raw async, active-high
//  running_out   out  1   1 = counting, 0 = stopped/paused
//  time_bcd_out  out  24  {min_t,min_o,sec_t,sec_o,cs_t,cs_o}, 4-bit BCD each
//  seg_out       out  8   {dp,g,f,e,d,c,b,a}, active-low
//  an_out        out  6   digit enables, active-low, an_out[0]=cs_o .. an_out[5]=min_t
// BEHAVIOUR
//  Reset (sys_rst_in=1 at an edge): running_out=0, time_bcd_out=0, prescaler=0, sync FFs and
//   debounce counters=0, scan index=0, seg_out=8'hFF, an_out=6'h3F. Reset overrides everything.
//  Input path (per button): 2-FF synchronizer, then debounce counter: +1 on each high synced sample,
//   cleared on a low sample, saturates at DEBOUNCE_CYCLES. One-cycle event is registered on the edge the
//   counter reaches DEBOUNCE_CYCLES. Holding gives one event; a low sample is required to rearm.
//   Pulses of <=DEBOUNCE_CYCLES-1 clocks (e.g. 9 ms, 7 ms) produce no event.
//  Latency: first edge sampling the button high = edge 0; event registered at edge 11;
//   running_out / counter-clear take effect at edge 12.
//  Control FSM: STOPPED (running_out=0) <-> RUNNING (running_out=1).
//   ps event: STOPPED->RUNNING, RUNNING->STOPPED (pause keeps time and prescaler value).
//   rst event: clears time_bcd_out and prescaler, forces STOPPED, from either state.
//   ps and rst event in the same cycle: rst wins (STOPPED, time cleared).
//  Timebase: prescaler counts 0..TICK_DIV-1 only in RUNNING; the wrap cycle increments cs_o.
//  BCD cascade: cs_o 9->0 carries cs_t; cs_t 9->0 carries sec_o; sec_o 9->0 carries sec_t;
//   sec_t 5->0 carries min_o; min_o 9->0 carries min_t; min_t 5->0. 59:59.99 -> 00:00.00, keeps running.
//   Digits never hold non-BCD values.
//  Display scan: 3-bit index cycles 0..5 every clock.
//   Index i drives an_out bit i low (others high) and seg_out with digit i's pattern.
//   Decimal point on (seg_out[7]=0) for sec_o and min_o; off elsewhere. Outputs registered, 1-clock lag.
//  time_bcd_out and running_out are registered state, not combinational.
// TESTING
//  1. sys_rst_in high 1 clk -> running_out=0, time_bcd_out=0, an_out=6'h3F.
//     Next clk: exactly one an_out bit low.
//  2. ps_in high 9 clks, then low -> no state change.
//     ps_in high 10 clks -> running_out=1 at edge 12; after 1000 clks time=00:01.00 (+-1 cs).
//  3. Running, ps_in high 15 clks -> running_out=0, time frozen across 1000 clks.
//     Press again -> resumes from the frozen value with no skipped count.
//  4. Paused at nonzero time: rst_in high 7 clks -> unchanged.
//     rst_in high 10 clks -> time_bcd_out=0, running_out=0.
//     rst_in during RUNNING -> cleared and stopped.
//  5. Preload/run to 59:59.99, one tick -> 00:00.00, running_out still 1.
//     Check 00:09.99->00:10.00 and 00:59.99->01:00.00.
//  6. ps and rst events in the same cycle -> STOPPED, time 0.
//     ps held 3000 clks -> exactly one toggle.

Source files
------------

// File: rtl/stopwatch_core.sv
// Two-button MM:SS.cc stopwatch: debounced start/pause and clear buttons, BCD time counter,
// and a six-digit multiplexed active-low 7-segment display driver.
module stopwatch_core #(
    parameter int DEBOUNCE_CYCLES = 10,
    parameter int TICK_DIV        = 10
) (
    input  logic        clk_in,
    input  logic        sys_rst_in,
    input  logic        ps_in,
    input  logic        rst_in,
    output logic        running_out,
    output logic [23:0] time_bcd_out,
    output logic [7:0]  seg_out,
    output logic [5:0]  an_out
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } state_t;

    // Bit 0 is the start/pause button, bit 1 the clear button.
    logic [1:0]      sync1_q, sync1_d;
    logic [1:0]      sync2_q, sync2_d;
    logic [DB_W-1:0] cnt_q [2];
    logic [DB_W-1:0] cnt_d [2];
    logic [1:0]      ev_q, ev_d;

    state_t          state_q, state_d;
    logic [PS_W-1:0] pre_q, pre_d;
    logic [23:0]     time_q, time_d;

    logic [2:0]      scan_q, scan_d;
    logic [7:0]      seg_q, seg_d;
    logic [5:0]      an_q, an_d;
    logic [3:0]      digit;

    // Digits wrap at their limit (5 for tens of seconds/minutes, 9 otherwise); any value at or
    // above the limit collapses to 0 so a digit can never leave the BCD range.
    function automatic logic [23:0] bcd_inc(input logic [23:0] t);
        logic [23:0] r;
        logic        carry;
        logic [3:0]  lim;
        r     = t;
        carry = 1'b1;
        for (int i = 0; i < 6; i++) begin
            lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
            if (carry) begin
                if (r[4*i +: 4] >= lim) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7_n(input logic [3:0] d);
        case (d)
            4'd0:    seg7_n = 7'h40;
            4'd1:    seg7_n = 7'h79;
            4'd2:    seg7_n = 7'h24;
            4'd3:    seg7_n = 7'h30;
            4'd4:    seg7_n = 7'h19;
            4'd5:    seg7_n = 7'h12;
            4'd6:    seg7_n = 7'h02;
            4'd7:    seg7_n = 7'h78;
            4'd8:    seg7_n = 7'h00;
            4'd9:    seg7_n = 7'h10;
            default: seg7_n = 7'h7F;
        endcase
    endfunction

    // The event fires on the sample that brings the counter to DEBOUNCE_CYCLES; saturation
    // then holds it there until a low sample rearms the button.
    always_comb begin
        sync1_d = {rst_in, ps_in};
        sync2_d = sync1_q;
        ev_d    = 2'b00;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = cnt_q[i];
            if (!sync2_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] < DB_W'(DEBOUNCE_CYCLES)) begin
                cnt_d[i] = cnt_q[i] + DB_W'(1);
            end
            ev_d[i] = sync2_q[i] && (cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1));
        end
    end

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        time_d  = time_q;
        if (state_q == RUNNING) begin
            if (pre_q == PS_W'(TICK_DIV - 1)) begin
                pre_d  = '0;
                time_d = bcd_inc(time_q);
            end else begin
                pre_d = pre_q + PS_W'(1);
            end
        end
        // Clear has priority over start/pause when both events land together.
        if (ev_q[1]) begin
            state_d = STOPPED;
            pre_d   = '0;
            time_d  = '0;
        end else if (ev_q[0]) begin
            state_d = (state_q == RUNNING) ? STOPPED : RUNNING;
        end
    end

    always_comb begin
        scan_d = (scan_q == 3'd5) ? 3'd0 : scan_q + 3'd1;
        digit  = 4'hF;
        an_d   = 6'h3F;
        case (scan_q)
            3'd0: begin digit = time_q[3:0];   an_d = 6'b111110; end
            3'd1: begin digit = time_q[7:4];   an_d = 6'b111101; end
            3'd2: begin digit = time_q[11:8];  an_d = 6'b111011; end
            3'd3: begin digit = time_q[15:12]; an_d = 6'b110111; end
            3'd4: begin digit = time_q[19:16]; an_d = 6'b101111; end
            3'd5: begin digit = time_q[23:20]; an_d = 6'b011111; end
            default: begin digit = 4'hF;       an_d = 6'h3F;     end
        endcase
        seg_d = {!(scan_q == 3'd2 || scan_q == 3'd4), seg7_n(digit)};
    end

    always_ff @(posedge clk_in) begin
        if (sys_rst_in) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cnt_q   <= '{default: '0};
            ev_q    <= '0;
            state_q <= STOPPED;
            pre_q   <= '0;
            time_q  <= '0;
            scan_q  <= '0;
            seg_q   <= 8'hFF;
            an_q    <= 6'h3F;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            ev_q    <= ev_d;
            state_q <= state_d;
            pre_q   <= pre_d;
            time_q  <= time_d;
            scan_q  <= scan_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign running_out  = (state_q == RUNNING);
    assign time_bcd_out = time_q;
    assign seg_out      = seg_q;
    assign an_out       = an_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core: button latency, debounce rejection, pause/resume,
// clear priority and BCD rollover boundaries, all against hand-computed values.
module tb_stopwatch_core;

    logic        clk_in = 1'b0;
    logic        sys_rst_in;
    logic        ps_in;
    logic        rst_in;
    logic        running_out;
    logic [23:0] time_bcd_out;
    logic [7:0]  seg_out;
    logic [5:0]  an_out;

    int          checks = 0;
    int          errors = 0;
    logic [23:0] preload_val;

    stopwatch_core #(
        .DEBOUNCE_CYCLES(10),
        .TICK_DIV       (10)
    ) dut (
        .clk_in      (clk_in),
        .sys_rst_in  (sys_rst_in),
        .ps_in       (ps_in),
        .rst_in      (rst_in),
        .running_out (running_out),
        .time_bcd_out(time_bcd_out),
        .seg_out     (seg_out),
        .an_out      (an_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string tag, input logic [23:0] observed, input logic [23:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    // Holds the chosen buttons high for n clocks starting at the current negedge.
    task automatic applyStimulus(input logic ps, input logic rst, input int n);
        ps_in  = ps;
        rst_in = rst;
        wait_cycles(n);
        ps_in  = 1'b0;
        rst_in = 1'b0;
    endtask

    // Loads a time value while stopped: the held flop recirculates the forced value across one edge.
    task preload(input logic [23:0] v);
        preload_val = v;
        force dut.time_q = preload_val;
        @(posedge clk_in);
        @(negedge clk_in);
        release dut.time_q;
    endtask

    task automatic run_boundary(input string tag, input logic [23:0] start_v, input logic [23:0] after_v);
        applyStimulus(1'b0, 1'b1, 10);
        wait_cycles(3);
        preload(start_v);
        checkOutput({tag, "_preload"}, time_bcd_out, start_v);
        applyStimulus(1'b1, 1'b0, 10);
        wait_cycles(3);
        wait_cycles(9);
        checkOutput({tag, "_before"}, time_bcd_out, start_v);
        wait_cycles(1);
        checkOutput({tag, "_after"}, time_bcd_out, after_v);
        checkOutput({tag, "_run"}, 24'(running_out), 24'd1);
    endtask

    initial begin
        sys_rst_in = 1'b0;
        ps_in      = 1'b0;
        rst_in     = 1'b0;

        // Reset values and first display scan steps
        @(negedge clk_in);
        sys_rst_in = 1'b1;
        @(negedge clk_in);
        checkOutput("rst_run", 24'(running_out), 24'd0);
        checkOutput("rst_time", time_bcd_out, 24'h000000);
        checkOutput("rst_an", 24'(an_out), 24'h00003F);
        checkOutput("rst_seg", 24'(seg_out), 24'h0000FF);
        sys_rst_in = 1'b0;
        @(negedge clk_in);
        checkOutput("scan0_an", 24'(an_out), 24'h00003E);
        checkOutput("scan0_seg", 24'(seg_out), 24'h0000C0);
        @(negedge clk_in);
        checkOutput("scan1_an", 24'(an_out), 24'h00003D);
        checkOutput("scan1_seg", 24'(seg_out), 24'h0000C0);
        @(negedge clk_in);
        checkOutput("scan2_an", 24'(an_out), 24'h00003B);
        checkOutput("scan2_seg_dp", 24'(seg_out), 24'h000040);

        // Short press rejected, full press starts with exact latency
        applyStimulus(1'b1, 1'b0, 9);
        wait_cycles(20);
        checkOutput("short_ps_run", 24'(running_out), 24'd0);
        checkOutput("short_ps_time", time_bcd_out, 24'h000000);
        applyStimulus(1'b1, 1'b0, 10);
        wait_cycles(2);
        checkOutput("start_edge11", 24'(running_out), 24'd0);
        wait_cycles(1);
        checkOutput("start_edge12", 24'(running_out), 24'd1);
        wait_cycles(1000);
        checkOutput("one_second", time_bcd_out, 24'h000100);

        // Pause keeps time and prescaler, resume continues without skipping
        applyStimulus(1'b1, 1'b0, 15);
        checkOutput("pause_run", 24'(running_out), 24'd0);
        checkOutput("pause_time", time_bcd_out, 24'h000101);
        wait_cycles(1000);
        checkOutput("frozen_time", time_bcd_out, 24'h000101);
        checkOutput("frozen_run", 24'(running_out), 24'd0);
        applyStimulus(1'b1, 1'b0, 10);
        wait_cycles(3);
        checkOutput("resume_run", 24'(running_out), 24'd1);
        wait_cycles(6);
        checkOutput("resume_hold", time_bcd_out, 24'h000101);
        wait_cycles(1);
        checkOutput("resume_tick", time_bcd_out, 24'h000102);

        // Clear while running
        applyStimulus(1'b0, 1'b1, 10);
        wait_cycles(2);
        checkOutput("clr_edge11_run", 24'(running_out), 24'd1);
        wait_cycles(1);
        checkOutput("clr_run", 24'(running_out), 24'd0);
        checkOutput("clr_time", time_bcd_out, 24'h000000);

        // Clear while paused at a nonzero time: short press ignored, full press clears
        preload(24'h001234);
        checkOutput("paused_preload", time_bcd_out, 24'h001234);
        applyStimulus(1'b0, 1'b1, 7);
        wait_cycles(20);
        checkOutput("short_clr_time", time_bcd_out, 24'h001234);
        checkOutput("short_clr_run", 24'(running_out), 24'd0);
        applyStimulus(1'b0, 1'b1, 10);
        wait_cycles(3);
        checkOutput("paused_clr_time", time_bcd_out, 24'h000000);
        checkOutput("paused_clr_run", 24'(running_out), 24'd0);

        // Cascade boundaries
        run_boundary("wrap", 24'h595999, 24'h000000);
        run_boundary("sec10", 24'h000999, 24'h001000);
        run_boundary("min1", 24'h005999, 24'h010000);

        // Simultaneous start/pause and clear: clear wins
        applyStimulus(1'b0, 1'b1, 10);
        wait_cycles(3);
        preload(24'h000512);
        applyStimulus(1'b1, 1'b1, 10);
        wait_cycles(3);
        checkOutput("both_run", 24'(running_out), 24'd0);
        checkOutput("both_time", time_bcd_out, 24'h000000);
        wait_cycles(20);
        checkOutput("both_run_later", 24'(running_out), 24'd0);

        // Long hold toggles exactly once
        applyStimulus(1'b1, 1'b0, 3000);
        checkOutput("hold_run", 24'(running_out), 24'd1);
        checkOutput("hold_time", time_bcd_out, 24'h000298);
        wait_cycles(50);
        checkOutput("hold_run_after", 24'(running_out), 24'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
